// File: rtl/accum_core_gen2.sv
// ---------------------------------------------------------------------------
// accum_core_gen2
// Parametrised accumulator processor with a serial load/readback port for
// its instruction and data memories, an explicit HALT opcode and a
// saturating retired-instruction counter.
//
// Instruction word = {operand[ADDR_W-1:0], opcode[3:0]}.
// Serial frame (MSB first, one bit per clk while in SHIFT):
//   {cmd(1), addr(ADDR_W), payload(P)}, P = max(DATA_W, ADDR_W+4)
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   run_in            1 = execute program, 0 = idle / serial access
//   cs_i_n, cs_d_n    serial selects for instruction / data memory
//   mosi_in           serial data in
//   miso_out          serial readback data
//   pc_out, acc_out   program counter, accumulator
//   halted_out        program terminated
//   frame_err_out     last serial frame malformed (sticky)
//   icount_out        retired instructions since run entry, saturating
// ---------------------------------------------------------------------------
module accum_core_gen2 #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run_in,
    input  logic              cs_i_n,
    input  logic              cs_d_n,
    input  logic              mosi_in,
    output logic              miso_out,
    output logic [ADDR_W-1:0] pc_out,
    output logic [DATA_W-1:0] acc_out,
    output logic              halted_out,
    output logic              frame_err_out,
    output logic [CNT_W-1:0]  icount_out
);

    localparam int IW    = ADDR_W + 4;
    localparam int P     = (DATA_W > IW) ? DATA_W : IW;
    localparam int L     = 1 + ADDR_W + P;
    localparam int DEPTH = 1 << ADDR_W;
    localparam int CW    = $clog2(L + 2);

    localparam logic [CW-1:0]     CNT_SAT  = CW'(L + 1);
    localparam logic [CW-1:0]     CNT_LEN  = CW'(L);
    localparam logic [CW-1:0]     CNT_ADDR = CW'(ADDR_W);
    localparam logic [ADDR_W-1:0] PC_LAST  = {ADDR_W{1'b1}};
    localparam logic [CNT_W-1:0]  IC_SAT   = {CNT_W{1'b1}};

    localparam logic [3:0] OP_LD   = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_XOR  = 4'h5;
    localparam logic [3:0] OP_SHL1 = 4'h6;
    localparam logic [3:0] OP_SHR1 = 4'h7;
    localparam logic [3:0] OP_LDI  = 4'h8;
    localparam logic [3:0] OP_ADDI = 4'h9;
    localparam logic [3:0] OP_ST   = 4'hA;
    localparam logic [3:0] OP_NOT  = 4'hB;
    localparam logic [3:0] OP_HALT = 4'hE;
    localparam logic [3:0] OP_BNEZ = 4'hF;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_EXEC  = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [DATA_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]    icount_q, icount_d;
    logic                halted_q, halted_d;
    logic                ferr_q, ferr_d;
    logic                miso_q, miso_d;
    logic                sel_i_q, sel_i_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [L-1:0]        sh_q, sh_d;
    logic [P-1:0]        rsh_q, rsh_d;

    logic [IW-1:0]       imem_q [DEPTH];
    logic [DATA_W-1:0]   dmem_q [DEPTH];

    logic                imem_we_s;
    logic                dmem_we_s;
    logic [ADDR_W-1:0]   mem_waddr_s;
    logic [IW-1:0]       imem_wdata_s;
    logic [DATA_W-1:0]   dmem_wdata_s;

    // Fetch and operand decode are purely combinational reads.
    logic [IW-1:0]       instr_s;
    logic [3:0]          opc_s;
    logic [ADDR_W-1:0]   opnd_s;
    logic [DATA_W-1:0]   mem_s;
    logic [DATA_W-1:0]   imm_s;
    logic                taken_s;

    assign instr_s = imem_q[pc_q];
    assign opc_s   = instr_s[3:0];
    assign opnd_s  = instr_s[IW-1:4];
    assign mem_s   = dmem_q[opnd_s];
    assign imm_s   = DATA_W'($signed(opnd_s));
    assign taken_s = (opc_s == OP_BNEZ) && (acc_q != '0);

    // Serial frame helpers: the address is complete in sh_next_s on the edge
    // that samples the last address bit, so readback can start right after.
    logic [L-1:0]        sh_next_s;
    logic [ADDR_W-1:0]   rd_addr_s;
    logic [P-1:0]        rd_word_s;
    logic                other_low_s;
    logic                sel_high_s;

    assign sh_next_s   = {sh_q[L-2:0], mosi_in};
    assign rd_addr_s   = sh_next_s[ADDR_W-1:0];
    assign rd_word_s   = sel_i_q ? P'(imem_q[rd_addr_s]) : P'(dmem_q[rd_addr_s]);
    assign other_low_s = sel_i_q ? ~cs_d_n : ~cs_i_n;
    assign sel_high_s  = sel_i_q ? cs_i_n : cs_d_n;

    // Next-state, datapath and memory-write decode.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        acc_d        = acc_q;
        icount_d     = icount_q;
        halted_d     = halted_q;
        ferr_d       = ferr_q;
        miso_d       = 1'b0;
        sel_i_d      = sel_i_q;
        cnt_d        = cnt_q;
        sh_d         = sh_q;
        rsh_d        = rsh_q;
        imem_we_s    = 1'b0;
        dmem_we_s    = 1'b0;
        mem_waddr_s  = sh_q[P +: ADDR_W];
        imem_wdata_s = sh_q[IW-1:0];
        dmem_wdata_s = sh_q[DATA_W-1:0];

        case (state_q)
            S_IDLE: begin
                if (run_in) begin
                    state_d  = S_EXEC;
                    pc_d     = '0;
                    acc_d    = '0;
                    icount_d = '0;
                    halted_d = 1'b0;
                end else if (cs_i_n != cs_d_n) begin
                    state_d = S_SHIFT;
                    sel_i_d = ~cs_i_n;
                    cnt_d   = '0;
                    sh_d    = '0;
                    rsh_d   = '0;
                end else if (!cs_i_n && !cs_d_n) begin
                    ferr_d = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_SHIFT: begin
                if (other_low_s) begin
                    // The other memory was selected mid-frame: abort.
                    state_d = S_IDLE;
                    ferr_d  = 1'b1;
                end else if (sel_high_s) begin
                    state_d = S_IDLE;
                    if (cnt_q == CNT_LEN) begin
                        ferr_d = 1'b0;
                        if (sh_q[L-1]) begin
                            if (sel_i_q) begin
                                imem_we_s = 1'b1;
                            end else begin
                                dmem_we_s = 1'b1;
                            end
                        end else begin
                            ferr_d = 1'b0;
                        end
                    end else begin
                        ferr_d = 1'b1;
                    end
                end else begin
                    sh_d  = sh_next_s;
                    cnt_d = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CW'(1);
                    // cmd bit sits at sh_q[ADDR_W-1] while the last address bit arrives.
                    if ((cnt_q == CNT_ADDR) && !sh_q[ADDR_W-1]) begin
                        miso_d = rd_word_s[P-1];
                        rsh_d  = rd_word_s << 1;
                    end else begin
                        miso_d = rsh_q[P-1];
                        rsh_d  = rsh_q << 1;
                    end
                end
            end

            S_EXEC: begin
                if (!run_in) begin
                    state_d = S_IDLE;
                end else if (opc_s == OP_HALT) begin
                    // HALT is not retired.
                    state_d  = S_HALT;
                    halted_d = 1'b1;
                end else begin
                    case (opc_s)
                        OP_LD:   acc_d = mem_s;
                        OP_ADD:  acc_d = acc_q + mem_s;
                        OP_SUB:  acc_d = acc_q - mem_s;
                        OP_AND:  acc_d = acc_q & mem_s;
                        OP_OR:   acc_d = acc_q | mem_s;
                        OP_XOR:  acc_d = acc_q ^ mem_s;
                        OP_SHL1: acc_d = acc_q << 1;
                        OP_SHR1: acc_d = acc_q >> 1;
                        OP_LDI:  acc_d = imm_s;
                        OP_ADDI: acc_d = acc_q + imm_s;
                        OP_ST: begin
                            dmem_we_s    = 1'b1;
                            mem_waddr_s  = opnd_s;
                            dmem_wdata_s = acc_q;
                        end
                        OP_NOT:  acc_d = ~acc_q;
                        default: acc_d = acc_q;
                    endcase
                    icount_d = (icount_q == IC_SAT) ? icount_q : icount_q + CNT_W'(1);
                    if (taken_s) begin
                        pc_d = opnd_s;
                    end else if (pc_q == PC_LAST) begin
                        // Fell off the end of imem: retire, then stop in place.
                        state_d  = S_HALT;
                        halted_d = 1'b1;
                    end else begin
                        pc_d = pc_q + ADDR_W'(1);
                    end
                end
            end

            S_HALT: begin
                if (!run_in) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_HALT;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            pc_q     <= '0;
            acc_q    <= '0;
            icount_q <= '0;
            halted_q <= 1'b0;
            ferr_q   <= 1'b0;
            miso_q   <= 1'b0;
            sel_i_q  <= 1'b0;
            cnt_q    <= '0;
            sh_q     <= '0;
            rsh_q    <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            acc_q    <= acc_d;
            icount_q <= icount_d;
            halted_q <= halted_d;
            ferr_q   <= ferr_d;
            miso_q   <= miso_d;
            sel_i_q  <= sel_i_d;
            cnt_q    <= cnt_d;
            sh_q     <= sh_d;
            rsh_q    <= rsh_d;
        end
    end

    // Instruction and data memories, cleared by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                imem_q[i] <= '0;
                dmem_q[i] <= '0;
            end
        end else begin
            if (imem_we_s) begin
                imem_q[mem_waddr_s] <= imem_wdata_s;
            end
            if (dmem_we_s) begin
                dmem_q[mem_waddr_s] <= dmem_wdata_s;
            end
        end
    end

    assign miso_out      = miso_q;
    assign pc_out        = pc_q;
    assign acc_out       = acc_q;
    assign halted_out    = halted_q;
    assign frame_err_out = ferr_q;
    assign icount_out    = icount_q;

endmodule

// File: doc/accum_core_gen2.md
Name: accum_core_gen2

Overview:
Parametrised second-generation accumulator processor. It has a generic data width and address width, and a dual-target serial load/readback port for both instruction and data memory. It adds an explicit HALT opcode, a halted flag, a frame-error flag and a saturating retired-instruction counter. It sits under the tile top; the top maps run_in, cs_i_n, cs_d_n, mosi_in and miso_out onto bidirectional pins and drives its display from pc_out.

Parameters:
DATA_W, 8, accumulator / data memory word width (>=4)
ADDR_W, 4, address width; both memories have depth 2**ADDR_W; instruction = {operand[ADDR_W-1:0], opcode[3:0]}
CNT_W, 8, retired-instruction counter width

Ports:
clk  in  1  clock
rst_n  in  1  reset
run_in  in  1  high = execute program, low = stop/idle
cs_i_n  in  1  serial select, instruction memory, active low
cs_d_n  in  1  serial select, data memory, active low
mosi_in  in  1  serial data in, sampled on clk rising edge
miso_out  out  1  serial readback data
pc_out  out  ADDR_W  program counter
acc_out  out  DATA_W  accumulator
halted_out  out  1  program terminated
frame_err_out  out  1  last serial frame malformed (sticky)
icount_out  out  CNT_W  retired instructions since RUN entry, saturating

Behaviour:
- Reset: one clock, clk; reset is asynchronous and active-low (rst_n). All state clears: FSM=IDLE, pc/acc/icount=0, both memories=0, miso_out=0, halted_out=0, frame_err_out=0.
- FSM states: IDLE, SHIFT, EXEC, HALT.
- IDLE -> EXEC when run_in=1. run_in has priority over any chip-select.
- IDLE -> SHIFT when exactly one cs is low and run_in=0.
- SHIFT -> IDLE when the selected cs rises. A change of cs during a frame (the other cs falls) aborts the frame and sets frame_err.
- EXEC -> HALT on a halt condition. EXEC or HALT -> IDLE when run_in=0.
- Entering EXEC: pc=0, acc=0, icount=0, halted=0. Memory contents are kept.
- Serial frame, MSB first, one bit per clk while in SHIFT. Length L = 1 + ADDR_W + P, where P = max(DATA_W, ADDR_W+4).
  - Bit 0 is the command: 1 = write, 0 = read.
  - The next ADDR_W bits are the address. The next P bits are the payload; instruction memory uses the low ADDR_W+4 bits, data memory the low DATA_W bits.
  - Write: commits one cycle after cs rises, only if exactly L bits were shifted. Any other count discards the write and sets frame_err.
  - Read: starting the cycle after the last address bit is sampled, miso_out drives the addressed word MSB first (zero-extended to P), one bit per clk. miso_out=0 otherwise.
  - A valid frame clears frame_err at commit/completion.
  - Both cs low at IDLE is ignored and sets frame_err. A cs low during EXEC or HALT is ignored and sets nothing.
- EXEC executes one instruction per clk; there is no pipeline hazard, because fetch is a combinational memory read.
- Opcodes; mem = dmem[operand], imm = operand sign-extended to DATA_W:
  - 0 LD: acc=mem
  - 1 ADD: acc=acc+mem
  - 2 SUB: acc=acc-mem
  - 3 AND, 4 OR, 5 XOR: acc=acc op mem
  - 6 SHL1, 7 SHR1 (logical): operand ignored
  - 8 LDI: acc=imm
  - 9 ADDI: acc=acc+imm
  - A ST: dmem[operand]=acc, acc unchanged
  - B NOT: acc=~acc
  - C, D: NOP
  - E HALT
  - F BNEZ: if acc!=0, pc=operand
  - Arithmetic is modulo 2**DATA_W with no flags.
- pc increments modulo 2**ADDR_W, except on a taken branch.
- Halt conditions (checked in EXEC):
  - Opcode E is fetched. It is not retired and acc is unchanged.
  - A non-taken-branch instruction is executed at pc = 2**ADDR_W-1. That instruction is retired, then the core halts with pc unchanged.
  - In HALT: halted_out=1; pc, acc and icount are frozen.
- icount increments per retired instruction in EXEC and saturates at 2**CNT_W-1.
- Reset mid-frame discards the frame. Reset mid-run returns to IDLE with cleared state.

Test Plan:
- Write instruction frame: cs_i_n low, shift 1, addr 0011, payload 0x85 (P=8), cs_i_n high -> imem[3]=0x85, frame_err_out=0.
- Short frame: shift 7 bits on cs_d_n then release -> no write, frame_err_out=1; the next valid frame clears it.
- Readback: dmem[5]=0xA7, read frame to addr 0101 -> miso_out bits 1,0,1,0,0,1,1,1 on the 8 cycles after the address.
- Program [LDI 3, ADDI -1 (0xF9), BNEZ 1, ST 2, HALT] with run_in=1:
  - Expected: dmem[2]=0, acc_out=0, halted_out=1, pc_out=4, icount_out=8.
- Fall-through: imem all NOP, run -> after 16 cycles halted_out=1, pc_out=15, icount_out=16.
- Async reset: assert rst_n=0 mid-EXEC between edges -> pc_out, acc_out, icount_out and halted_out read 0 immediately; the FSM returns to IDLE.
